// File: rtl/ctrl_pipe_regs.sv
// Control-bundle pipeline registers (ID/EX, EX/MEM, MEM/WB) for the MIPS pipeline.
// Inserts bubbles on load-use hazards and taken branches and freezes on a global hold.
module ctrl_pipe_regs #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  regdst,
    input  logic                  ULAsrc,
    input  logic                  memtoreg,
    input  logic                  regwrite,
    input  logic                  memread,
    input  logic                  memwrite,
    input  logic                  branch,
    input  logic [1:0]            ULAop,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  hold,
    input  logic                  branch_taken,
    output logic                  load_use_stall,
    output logic                  ex_valid,
    output logic                  ex_ULAsrc,
    output logic                  ex_memread,
    output logic [1:0]            ex_ULAop,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic                  mem_valid,
    output logic                  mem_memread,
    output logic                  mem_memwrite,
    output logic                  mem_branch,
    output logic [REG_ADDR_W-1:0] mem_dest,
    output logic                  wb_valid,
    output logic                  wb_regwrite,
    output logic                  wb_memtoreg,
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic [CNT_W-1:0]      bubble_cnt
);

    typedef struct packed {
        logic                  valid;
        logic                  ulasrc;
        logic                  memread;
        logic                  memwrite;
        logic                  branch;
        logic                  regwrite;
        logic                  memtoreg;
        logic [1:0]            ulaop;
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_ADDR_W-1:0] rt;
    } ex_t;

    typedef struct packed {
        logic                  valid;
        logic                  memread;
        logic                  memwrite;
        logic                  branch;
        logic                  regwrite;
        logic                  memtoreg;
        logic [REG_ADDR_W-1:0] dest;
    } mem_t;

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic                  memtoreg;
        logic [REG_ADDR_W-1:0] dest;
    } wb_t;

    ex_t             ex_q,  ex_d,  id_bundle;
    mem_t            mem_q, mem_d, ex_as_mem;
    wb_t             wb_q,  wb_d,  mem_as_wb;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       inc;
    logic [CNT_W:0]   cnt_sum;

    assign load_use_stall = ex_q.valid & ex_q.memread & (ex_q.rt != '0) &
                            ((ex_q.rt == id_rs) | (ex_q.rt == id_rt)) & id_valid;

    // Stage-to-stage views: each stage keeps only what downstream stages still consume.
    always_comb begin
        id_bundle = '0;
        if (id_valid) begin
            id_bundle.valid    = 1'b1;
            id_bundle.ulasrc   = ULAsrc;
            id_bundle.memread  = memread;
            id_bundle.memwrite = memwrite;
            id_bundle.branch   = branch;
            id_bundle.regwrite = regwrite;
            id_bundle.memtoreg = memtoreg;
            id_bundle.ulaop    = ULAop;
            id_bundle.dest     = regdst ? id_rd : id_rt;
            id_bundle.rt       = id_rt;
        end
        ex_as_mem = '{valid: ex_q.valid, memread: ex_q.memread, memwrite: ex_q.memwrite,
                      branch: ex_q.branch, regwrite: ex_q.regwrite,
                      memtoreg: ex_q.memtoreg, dest: ex_q.dest};
        mem_as_wb = '{valid: mem_q.valid, regwrite: mem_q.regwrite,
                      memtoreg: mem_q.memtoreg, dest: mem_q.dest};
    end

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        inc   = 2'd0;
        if (!hold) begin
            if (branch_taken) begin
                ex_d  = '0;
                mem_d = '0;
                wb_d  = mem_as_wb;
                inc   = 2'd2;
            end else if (load_use_stall) begin
                ex_d  = '0;
                mem_d = ex_as_mem;
                wb_d  = mem_as_wb;
                inc   = 2'd1;
            end else begin
                ex_d  = id_bundle;
                mem_d = ex_as_mem;
                wb_d  = mem_as_wb;
            end
        end
        cnt_sum = {1'b0, cnt_q} + (CNT_W + 1)'(inc);
        cnt_d   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    // NOTE: state registers use non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_ULAsrc    = ex_q.ulasrc;
    assign ex_memread   = ex_q.memread;
    assign ex_ULAop     = ex_q.ulaop;
    assign ex_dest      = ex_q.dest;
    assign mem_valid    = mem_q.valid;
    assign mem_memread  = mem_q.memread;
    assign mem_memwrite = mem_q.memwrite;
    assign mem_branch   = mem_q.branch;
    assign mem_dest     = mem_q.dest;
    assign wb_valid     = wb_q.valid;
    assign wb_regwrite  = wb_q.regwrite;
    assign wb_memtoreg  = wb_q.memtoreg;
    assign wb_dest      = wb_q.dest;
    assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Bench for ctrl_pipe_regs: directed scenarios with literal expectations plus random
// traffic compared every cycle against an instruction-level pipeline model.
module tb_ctrl_pipe_regs;

    typedef struct packed {
        bit       v;
        bit       regdst, ulasrc, memtoreg, regwrite, memread, memwrite, branch;
        bit [1:0] ulaop;
        bit [4:0] rs, rt, rd;
    } instr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hold = 1'b0;
    logic       branch_taken = 1'b0;
    instr_t     id_in = '0;

    logic       load_use_stall;
    logic       ex_valid, ex_ULAsrc, ex_memread;
    logic [1:0] ex_ULAop;
    logic [4:0] ex_dest, mem_dest, wb_dest;
    logic       mem_valid, mem_memread, mem_memwrite, mem_branch;
    logic       wb_valid, wb_regwrite, wb_memtoreg;
    logic [7:0] bubble_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model: the instruction occupying each of EX, MEM, WB, and the raw bubble total.
    instr_t pipe [3];
    int     bubbles;

    always #5 clk = ~clk;

    ctrl_pipe_regs #(.REG_ADDR_W(5), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .regdst(id_in.regdst), .ULAsrc(id_in.ulasrc), .memtoreg(id_in.memtoreg),
        .regwrite(id_in.regwrite), .memread(id_in.memread), .memwrite(id_in.memwrite),
        .branch(id_in.branch), .ULAop(id_in.ulaop), .id_valid(id_in.v),
        .id_rs(id_in.rs), .id_rt(id_in.rt), .id_rd(id_in.rd),
        .hold(hold), .branch_taken(branch_taken), .load_use_stall(load_use_stall),
        .ex_valid(ex_valid), .ex_ULAsrc(ex_ULAsrc), .ex_memread(ex_memread),
        .ex_ULAop(ex_ULAop), .ex_dest(ex_dest),
        .mem_valid(mem_valid), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_branch(mem_branch), .mem_dest(mem_dest),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
        .wb_dest(wb_dest), .bubble_cnt(bubble_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [4:0] dest_of(instr_t i);
        return i.regdst ? i.rd : i.rt;
    endfunction

    function automatic bit model_stall();
        instr_t e = pipe[0];
        return e.v && e.memread && e.rt != 0 && (e.rt == id_in.rs || e.rt == id_in.rt) && id_in.v;
    endfunction

    function automatic int sat_cnt();
        return (bubbles > 255) ? 255 : bubbles;
    endfunction

    task automatic model_clear();
        foreach (pipe[k]) pipe[k] = '0;
        bubbles = 0;
    endtask

    task automatic model_edge();
        if (hold) return;
        if (branch_taken) begin
            pipe[2] = pipe[1];
            pipe[1] = '0;
            pipe[0] = '0;
            bubbles += 2;
        end else if (model_stall()) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = '0;
            bubbles += 1;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = id_in.v ? id_in : instr_t'(0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_edge();
        #1;
    endtask

    // Single compare process: every falling edge, every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("stall", load_use_stall, model_stall());
            check("ex_valid", ex_valid, pipe[0].v);
            check("ex_ULAsrc", ex_ULAsrc, pipe[0].ulasrc);
            check("ex_memread", ex_memread, pipe[0].memread);
            check("ex_ULAop", ex_ULAop, pipe[0].ulaop);
            if (pipe[0].v) check("ex_dest", ex_dest, dest_of(pipe[0]));
            check("mem_valid", mem_valid, pipe[1].v);
            check("mem_memread", mem_memread, pipe[1].memread);
            check("mem_memwrite", mem_memwrite, pipe[1].memwrite);
            check("mem_branch", mem_branch, pipe[1].branch);
            if (pipe[1].v) check("mem_dest", mem_dest, dest_of(pipe[1]));
            check("wb_valid", wb_valid, pipe[2].v);
            check("wb_regwrite", wb_regwrite, pipe[2].regwrite);
            check("wb_memtoreg", wb_memtoreg, pipe[2].memtoreg);
            if (pipe[2].v) check("wb_dest", wb_dest, dest_of(pipe[2]));
            check("bubble_cnt", bubble_cnt, sat_cnt());
        end
    end

    task automatic reset_mid_cycle();
        @(posedge clk);
        #2 reset = 1'b0;
        model_clear();
        #1;
        check("rst_stall", load_use_stall, 0);
        check("rst_ex", {ex_valid, ex_ULAsrc, ex_memread, ex_ULAop, ex_dest}, 0);
        check("rst_mem", {mem_valid, mem_memread, mem_memwrite, mem_branch, mem_dest}, 0);
        check("rst_wb", {wb_valid, wb_regwrite, wb_memtoreg, wb_dest}, 0);
        check("rst_cnt", bubble_cnt, 0);
        #4 reset = 1'b1;
    endtask

    function automatic instr_t mk(bit [4:0] rs, bit [4:0] rt, bit [4:0] rd);
        instr_t i = '0;
        i.v = 1'b1; i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction

    initial begin
        instr_t t;
        model_clear();
        #17 reset = 1'b1;
        cmp_en = 1'b1;

        // R-format propagation and latency
        t = mk(5'd1, 5'd7, 5'd5); t.regdst = 1; t.regwrite = 1; t.ulaop = 2'b10;
        id_in = t;
        step();
        id_in = '0;
        #1;
        check("r_ex_valid", ex_valid, 1);
        check("r_ex_ULAop", ex_ULAop, 2);
        check("r_ex_dest", ex_dest, 5);
        step(); step();
        check("r_wb_regwrite", wb_regwrite, 1);
        check("r_wb_dest", wb_dest, 5);
        check("r_wb_memtoreg", wb_memtoreg, 0);

        // LW followed by dependent R-format
        t = mk(5'd2, 5'd8, 5'd0); t.memread = 1; t.regwrite = 1; t.memtoreg = 1; t.ulasrc = 1;
        id_in = t;
        step();
        t = mk(5'd8, 5'd9, 5'd10); t.regdst = 1; t.regwrite = 1; t.ulaop = 2'b10;
        id_in = t;
        #1 check("lu_stall", load_use_stall, 1);
        step();
        check("lu_bubble", ex_valid, 0);
        check("lu_cnt", bubble_cnt, 1);
        check("lu_stall_drop", load_use_stall, 0);
        step();
        check("lu_dep_in_ex", ex_valid, 1);
        check("lu_dep_dest", ex_dest, 10);

        // Load-use through $0 never stalls
        t = mk(5'd3, 5'd0, 5'd0); t.memread = 1; t.regwrite = 1;
        id_in = t;
        step();
        id_in = mk(5'd0, 5'd4, 5'd6);
        #1 check("z_stall", load_use_stall, 0);
        step();
        check("z_ex_valid", ex_valid, 1);
        check("z_cnt", bubble_cnt, 1);

        // Taken BEQ flushes EX and MEM
        t = mk(5'd1, 5'd2, 5'd0); t.branch = 1; t.ulaop = 2'b01;
        id_in = t;
        step();
        id_in = mk(5'd3, 5'd4, 5'd11);
        step();
        id_in = mk(5'd5, 5'd6, 5'd12);
        #1 check("beq_mem_branch", mem_branch, 1);
        branch_taken = 1'b1;
        step();
        branch_taken = 1'b0;
        check("beq_ex", ex_valid, 0);
        check("beq_mem", mem_valid, 0);
        check("beq_wb", wb_valid, 1);
        check("beq_cnt", bubble_cnt, 3);

        // Hold beats branch_taken; flush only once re-presented
        step();
        hold = 1'b1; branch_taken = 1'b1;
        step(); step();
        check("hold_cnt", bubble_cnt, 3);
        check("hold_ex", ex_valid, 1);
        hold = 1'b0; branch_taken = 1'b0;
        step();
        check("hold_rel_cnt", bubble_cnt, 3);
        branch_taken = 1'b1;
        step();
        branch_taken = 1'b0;
        check("hold_flush_cnt", bubble_cnt, 5);
        check("hold_flush_ex", ex_valid, 0);

        // Asynchronous reset, then saturation from zero
        reset_mid_cycle();
        branch_taken = 1'b1;
        repeat (127) step();
        check("sat_254", bubble_cnt, 254);
        step();
        check("sat_255", bubble_cnt, 255);
        repeat (22) step();
        check("sat_hold", bubble_cnt, 255);
        branch_taken = 1'b0;

        // Random traffic
        repeat (2000) begin
            t = '0;
            t.v = ($urandom_range(0, 3) != 0);
            {t.regdst, t.ulasrc, t.memtoreg, t.regwrite} = 4'($urandom);
            {t.memread, t.memwrite, t.branch} = 3'($urandom);
            t.ulaop = 2'($urandom);
            t.rs = 5'($urandom_range(0, 3));
            t.rt = 5'($urandom_range(0, 3));
            t.rd = 5'($urandom);
            id_in = t;
            hold = ($urandom_range(0, 7) == 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            step();
        end
        hold = 1'b0; branch_taken = 1'b0;

        reset_mid_cycle();
        step(); step();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_regs.md
Name: ctrl_pipe_regs

Overview:
- Carries the control bundle produced by main_control in ID through the ID/EX, EX/MEM and MEM/WB pipeline registers of the MIPS pipeline.
- Inserts bubbles on load-use hazards and on taken branches, and holds on a global stall.
- Delivers the stage-local control signals to EX, MEM and WB.
- Sits between main_control and the datapath stage registers.

Parameters:
- REG_ADDR_W, 5, register address width.
- CNT_W, 8, width of the saturating bubble counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous active-low reset.
- regdst, ULAsrc, memtoreg, regwrite, memread, memwrite, branch  in  1 each  ID-stage control from main_control.
- ULAop  in  2  ID-stage ALU op class.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt, id_rd  in  REG_ADDR_W  ID source and destination register fields.
- hold  in  1  global stall; all stage registers keep their value.
- branch_taken  in  1  branch resolved taken in MEM this cycle.
- load_use_stall  out  1  combinational; upstream must freeze PC and IF/ID.
- ex_valid, ex_ULAsrc, ex_memread  out  1 each  EX-stage control.
- ex_ULAop  out  2  EX-stage ALU op class.
- ex_dest  out  REG_ADDR_W  EX destination register.
- mem_valid, mem_memread, mem_memwrite, mem_branch  out  1 each  MEM-stage control.
- mem_dest  out  REG_ADDR_W  MEM destination register.
- wb_valid, wb_regwrite, wb_memtoreg  out  1 each  WB-stage control.
- wb_dest  out  REG_ADDR_W  WB destination register.
- bubble_cnt  out  CNT_W  number of inserted bubbles.

Behaviour:
- Reset (reset=0, asynchronous) clears every stage register and bubble_cnt to 0.
  - A cleared stage register is a bubble: valid=0 and all controls 0.
  - Reset mid-operation discards every in-flight instruction.
- Destination select happens at ID→EX capture: dest = regdst ? id_rd : id_rt.
  - The captured dest propagates unchanged to MEM and WB.
  - If regwrite=0, dest is still captured; consumers must gate it with regwrite.
- load_use_stall = ex_valid & ex_memread & (ex_rt≠0) & (ex_rt==id_rs | ex_rt==id_rt) & id_valid.
  - ex_rt is an internal copy of id_rt captured with the EX register.
- Per-edge update, in priority order:
  1. hold=1: all three registers keep their value; bubble_cnt unchanged; branch_taken is ignored and must be re-presented by its source.
  2. branch_taken=1:
     - EX ← bubble (kills the instruction in ID).
     - MEM ← bubble (kills the instruction in EX).
     - WB ← MEM contents (the branch itself).
     - bubble_cnt += 2.
  3. load_use_stall=1:
     - EX ← bubble.
     - MEM ← EX.
     - WB ← MEM.
     - bubble_cnt += 1.
  4. Otherwise:
     - EX ← ID bundle with valid=id_valid; all controls forced to 0 when id_valid=0.
     - MEM ← EX.
     - WB ← MEM.
- All outputs are registered except load_use_stall.
  - Latency from ID to EX outputs: 1 cycle; to MEM outputs: 2 cycles; to WB outputs: 3 cycles.
- bubble_cnt saturates at 2^CNT_W−1 and never wraps.
  - A +2 increment at 2^CNT_W−2 yields the saturated value 2^CNT_W−1.
- ex_ULAop, mem_branch and the other outputs are passed through unmodified; this block does no decoding.

Test Plan:
- R-format: id_valid=1, regdst=1, regwrite=1, ULAop=10, id_rd=5, id_rt=7.
  - Cycle+1: ex_valid=1, ex_ULAop=10, ex_dest=5.
  - Cycle+3: wb_regwrite=1, wb_dest=5, wb_memtoreg=0.
- LW then dependent R-format: LW with id_rt=8, memread=1; next instruction has id_rs=8.
  - load_use_stall=1 for exactly one cycle.
  - A bubble (ex_valid=0) appears in EX.
  - bubble_cnt=1.
  - The dependent instruction enters EX one cycle later.
- Load-use to $0: LW with id_rt=0, next instruction has id_rs=0.
  - load_use_stall=0; no bubble inserted.
- BEQ taken: branch=1, ULAop=01; branch_taken=1 when mem_branch=1.
  - Next edge: ex_valid=0, mem_valid=0, wb_valid=1 (the BEQ), bubble_cnt += 2.
- Hold with branch_taken=1 asserted together: all outputs frozen.
  - bubble_cnt unchanged.
  - The flush takes effect only after hold drops and branch_taken is re-presented.
- Saturation and reset:
  - Force 300 hazard cycles: bubble_cnt=255.
  - Assert reset mid-cycle: every output is 0 immediately, without waiting for a clock edge.
